tilelink_ad_arbiter: RTL and testbench

- Shares one TL-UL A/D slave port, e.g. `tilelink_ad_dummy` or a memory model, between two TL-UL masters.
- Typical masters: the Rocket I-side and D-side requesters in split-bus formal harnesses.
- Uses round-robin arbitration, one transaction in flight at a time.
- The grant is held from A-channel acceptance until the last D beat, and D responses are routed back to the granted master.

---
 rtl/tilelink_ad_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_tilelink_ad_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilelink_ad_arbiter.sv
// Round-robin arbiter sharing one TL-UL A/D slave port between two masters.
// A single transaction is in flight at a time; the grant is held until its last D beat.
module tilelink_ad_arbiter #(
  parameter int DATA_BYTES = 4,
  parameter int MAX_SIZE   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_bits_opcode,
  input  logic [2:0]  m0_a_bits_param,
  input  logic [3:0]  m0_a_bits_size,
  input  logic        m0_a_bits_source,
  input  logic [31:0] m0_a_bits_address,
  input  logic [3:0]  m0_a_bits_mask,
  input  logic [31:0] m0_a_bits_data,
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_bits_opcode,
  input  logic [2:0]  m1_a_bits_param,
  input  logic [3:0]  m1_a_bits_size,
  input  logic        m1_a_bits_source,
  input  logic [31:0] m1_a_bits_address,
  input  logic [3:0]  m1_a_bits_mask,
  input  logic [31:0] m1_a_bits_data,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  output logic [2:0]  m0_d_bits_opcode,
  output logic [1:0]  m0_d_bits_param,
  output logic [3:0]  m0_d_bits_size,
  output logic        m0_d_bits_source,
  output logic        m0_d_bits_sink,
  output logic [1:0]  m0_d_bits_addr_lo,
  output logic [31:0] m0_d_bits_data,
  output logic        m0_d_bits_error,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  m1_d_bits_opcode,
  output logic [1:0]  m1_d_bits_param,
  output logic [3:0]  m1_d_bits_size,
  output logic        m1_d_bits_source,
  output logic        m1_d_bits_sink,
  output logic [1:0]  m1_d_bits_addr_lo,
  output logic [31:0] m1_d_bits_data,
  output logic        m1_d_bits_error,
  output logic        s_a_valid,
  input  logic        s_a_ready,
  output logic [2:0]  s_a_bits_opcode,
  output logic [2:0]  s_a_bits_param,
  output logic [3:0]  s_a_bits_size,
  output logic        s_a_bits_source,
  output logic [31:0] s_a_bits_address,
  output logic [3:0]  s_a_bits_mask,
  output logic [31:0] s_a_bits_data,
  input  logic        s_d_valid,
  output logic        s_d_ready,
  input  logic [2:0]  s_d_bits_opcode,
  input  logic [1:0]  s_d_bits_param,
  input  logic [3:0]  s_d_bits_size,
  input  logic        s_d_bits_source,
  input  logic        s_d_bits_sink,
  input  logic [1:0]  s_d_bits_addr_lo,
  input  logic [31:0] s_d_bits_data,
  input  logic        s_d_bits_error,
  output logic        grant,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake rule on every channel: a beat transfers on a rising clock edge
  // where valid and ready are both high; valid never waits on ready.
  localparam int LOG2_DB = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        grant_nxt;
  logic        rr_prio, rr_prio_nxt;
  logic [8:0]  beats_left, beats_nxt;
  logic        sel_a_valid, sel_d_ready;
  logic [3:0]  clamp_size;
  logic [8:0]  a_beats;
  logic        data_op;

  assign sel_a_valid = grant ? m1_a_valid : m0_a_valid;
  assign sel_d_ready = grant ? m1_d_ready : m0_d_ready;

  assign s_a_bits_opcode  = grant ? m1_a_bits_opcode  : m0_a_bits_opcode;
  assign s_a_bits_param   = grant ? m1_a_bits_param   : m0_a_bits_param;
  assign s_a_bits_size    = grant ? m1_a_bits_size    : m0_a_bits_size;
  assign s_a_bits_source  = grant ? m1_a_bits_source  : m0_a_bits_source;
  assign s_a_bits_address = grant ? m1_a_bits_address : m0_a_bits_address;
  assign s_a_bits_mask    = grant ? m1_a_bits_mask    : m0_a_bits_mask;
  assign s_a_bits_data    = grant ? m1_a_bits_data    : m0_a_bits_data;

  // D payload is shared; only the granted master ever sees d_valid.
  assign m0_d_bits_opcode  = s_d_bits_opcode;
  assign m0_d_bits_param   = s_d_bits_param;
  assign m0_d_bits_size    = s_d_bits_size;
  assign m0_d_bits_source  = s_d_bits_source;
  assign m0_d_bits_sink    = s_d_bits_sink;
  assign m0_d_bits_addr_lo = s_d_bits_addr_lo;
  assign m0_d_bits_data    = s_d_bits_data;
  assign m0_d_bits_error   = s_d_bits_error;
  assign m1_d_bits_opcode  = s_d_bits_opcode;
  assign m1_d_bits_param   = s_d_bits_param;
  assign m1_d_bits_size    = s_d_bits_size;
  assign m1_d_bits_source  = s_d_bits_source;
  assign m1_d_bits_sink    = s_d_bits_sink;
  assign m1_d_bits_addr_lo = s_d_bits_addr_lo;
  assign m1_d_bits_data    = s_d_bits_data;
  assign m1_d_bits_error   = s_d_bits_error;

  // Get, Arithmetic and Logical return data sized by the request; all else is a single ack.
  always_comb begin
    data_op    = (s_a_bits_opcode == 3'd4) || (s_a_bits_opcode == 3'd2) ||
                 (s_a_bits_opcode == 3'd3);
    clamp_size = (s_a_bits_size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : s_a_bits_size;
    a_beats    = 9'd1;
    if (data_op && (clamp_size > 4'(LOG2_DB)))
      a_beats = 9'd1 << (clamp_size - 4'(LOG2_DB));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      rr_prio    <= 1'b0;
      beats_left <= 9'd0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_prio    <= rr_prio_nxt;
      beats_left <= beats_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_prio_nxt = rr_prio;
    beats_nxt   = beats_left;
    s_a_valid   = 1'b0;
    m0_a_ready  = 1'b0;
    m1_a_ready  = 1'b0;
    s_d_ready   = 1'b0;
    m0_d_valid  = 1'b0;
    m1_d_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_a_valid || m1_a_valid) begin
          grant_nxt = (m0_a_valid && m1_a_valid) ? rr_prio : m1_a_valid;
          state_nxt = REQ;
        end
      end
      REQ: begin
        s_a_valid  = sel_a_valid;
        m0_a_ready = s_a_ready & ~grant;
        m1_a_ready = s_a_ready & grant;
        // A master withdrawing its request before acceptance forfeits the grant.
        if (!sel_a_valid) begin
          state_nxt = IDLE;
        end else if (s_a_ready) begin
          beats_nxt = a_beats;
          state_nxt = RESP;
        end
      end
      RESP: begin
        m0_d_valid = s_d_valid & ~grant;
        m1_d_valid = s_d_valid & grant;
        s_d_ready  = sel_d_ready;
        if (s_d_valid && sel_d_ready) begin
          beats_nxt = beats_left - 9'd1;
          if (beats_left == 9'd1) begin
            state_nxt   = IDLE;
            rr_prio_nxt = ~grant;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_tilelink_ad_arbiter.sv
// Directed bench for tilelink_ad_arbiter: arbitration order, burst lengths,
// D routing, stalls, unsolicited slave responses and asynchronous reset.
module tb_tilelink_ad_arbiter;

  logic        clock, reset;
  logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [2:0]  m0_a_bits_opcode, m0_a_bits_param, m1_a_bits_opcode, m1_a_bits_param;
  logic [3:0]  m0_a_bits_size, m0_a_bits_mask, m1_a_bits_size, m1_a_bits_mask;
  logic        m0_a_bits_source, m1_a_bits_source;
  logic [31:0] m0_a_bits_address, m0_a_bits_data, m1_a_bits_address, m1_a_bits_data;
  logic        m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
  logic [2:0]  m0_d_bits_opcode, m1_d_bits_opcode;
  logic [1:0]  m0_d_bits_param, m1_d_bits_param, m0_d_bits_addr_lo, m1_d_bits_addr_lo;
  logic [3:0]  m0_d_bits_size, m1_d_bits_size;
  logic        m0_d_bits_source, m1_d_bits_source, m0_d_bits_sink, m1_d_bits_sink;
  logic [31:0] m0_d_bits_data, m1_d_bits_data;
  logic        m0_d_bits_error, m1_d_bits_error;
  logic        s_a_valid, s_a_ready;
  logic [2:0]  s_a_bits_opcode, s_a_bits_param;
  logic [3:0]  s_a_bits_size, s_a_bits_mask;
  logic        s_a_bits_source;
  logic [31:0] s_a_bits_address, s_a_bits_data;
  logic        s_d_valid, s_d_ready;
  logic [2:0]  s_d_bits_opcode;
  logic [1:0]  s_d_bits_param, s_d_bits_addr_lo;
  logic [3:0]  s_d_bits_size;
  logic        s_d_bits_source, s_d_bits_sink, s_d_bits_error;
  logic [31:0] s_d_bits_data;
  logic        grant, busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  tilelink_ad_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
    .m0_a_bits_opcode(m0_a_bits_opcode), .m0_a_bits_param(m0_a_bits_param),
    .m0_a_bits_size(m0_a_bits_size), .m0_a_bits_source(m0_a_bits_source),
    .m0_a_bits_address(m0_a_bits_address), .m0_a_bits_mask(m0_a_bits_mask),
    .m0_a_bits_data(m0_a_bits_data),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
    .m1_a_bits_opcode(m1_a_bits_opcode), .m1_a_bits_param(m1_a_bits_param),
    .m1_a_bits_size(m1_a_bits_size), .m1_a_bits_source(m1_a_bits_source),
    .m1_a_bits_address(m1_a_bits_address), .m1_a_bits_mask(m1_a_bits_mask),
    .m1_a_bits_data(m1_a_bits_data),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m0_d_bits_opcode(m0_d_bits_opcode), .m0_d_bits_param(m0_d_bits_param),
    .m0_d_bits_size(m0_d_bits_size), .m0_d_bits_source(m0_d_bits_source),
    .m0_d_bits_sink(m0_d_bits_sink), .m0_d_bits_addr_lo(m0_d_bits_addr_lo),
    .m0_d_bits_data(m0_d_bits_data), .m0_d_bits_error(m0_d_bits_error),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .m1_d_bits_opcode(m1_d_bits_opcode), .m1_d_bits_param(m1_d_bits_param),
    .m1_d_bits_size(m1_d_bits_size), .m1_d_bits_source(m1_d_bits_source),
    .m1_d_bits_sink(m1_d_bits_sink), .m1_d_bits_addr_lo(m1_d_bits_addr_lo),
    .m1_d_bits_data(m1_d_bits_data), .m1_d_bits_error(m1_d_bits_error),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_a_bits_opcode(s_a_bits_opcode), .s_a_bits_param(s_a_bits_param),
    .s_a_bits_size(s_a_bits_size), .s_a_bits_source(s_a_bits_source),
    .s_a_bits_address(s_a_bits_address), .s_a_bits_mask(s_a_bits_mask),
    .s_a_bits_data(s_a_bits_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .s_d_bits_opcode(s_d_bits_opcode), .s_d_bits_param(s_d_bits_param),
    .s_d_bits_size(s_d_bits_size), .s_d_bits_source(s_d_bits_source),
    .s_d_bits_sink(s_d_bits_sink), .s_d_bits_addr_lo(s_d_bits_addr_lo),
    .s_d_bits_data(s_d_bits_data), .s_d_bits_error(s_d_bits_error),
    .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input bit m, input bit v, input logic [2:0] op,
                       input logic [3:0] sz, input logic [31:0] addr);
    if (!m) begin
      m0_a_valid = v; m0_a_bits_opcode = op; m0_a_bits_param = 3'd0;
      m0_a_bits_size = sz; m0_a_bits_source = 1'b0; m0_a_bits_address = addr;
      m0_a_bits_mask = 4'hf; m0_a_bits_data = ~addr;
    end else begin
      m1_a_valid = v; m1_a_bits_opcode = op; m1_a_bits_param = 3'd0;
      m1_a_bits_size = sz; m1_a_bits_source = 1'b1; m1_a_bits_address = addr;
      m1_a_bits_mask = 4'hf; m1_a_bits_data = ~addr;
    end
  endtask

  // Waits (bounded) for REQ; returns the number of negedges waited.
  task automatic wait_req(output int k);
    k = 0;
    while (dbg_state != 2'd1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("req_reached", 32'(k < 40), 32'd1);
  endtask

  // Zero-wait slave serving one transaction for master m with nbeats D beats.
  task automatic serve(input bit m, input int nbeats, input logic [31:0] addr,
                       input logic [31:0] d0, input bit keep, input bit raise_other,
                       input int exp_wait);
    int k;
    logic [31:0] exp;
    wait_req(k);
    if (exp_wait >= 0) check("idle_cycles", 32'(k), 32'(exp_wait));
    #1;
    check("grant", 32'(grant), 32'(m));
    check("s_a_valid_req", 32'(s_a_valid), 32'd1);
    check("s_a_addr", s_a_bits_address, addr);
    check("s_a_source", 32'(s_a_bits_source), 32'(m));
    check("a_ready_sel", 32'(m ? m1_a_ready : m0_a_ready), 32'd1);
    check("a_ready_other", 32'(m ? m0_a_ready : m1_a_ready), 32'd0);
    @(negedge clock);
    if (!keep) begin
      if (m) m1_a_valid = 1'b0; else m0_a_valid = 1'b0;
    end
    if (raise_other) set_a(!m, 1'b1, 3'd4, 4'd2, 32'h2000);
    for (int i = 0; i < nbeats; i++) begin
      s_d_valid = 1'b1;
      s_d_bits_data = d0 + 32'(i);
      exp_q.push_back(d0 + 32'(i));
      m0_d_ready = 1'b1;
      m1_d_ready = 1'b1;
      #1;
      check("d_valid_sel", 32'(m ? m1_d_valid : m0_d_valid), 32'd1);
      check("d_valid_other", 32'(m ? m0_d_valid : m1_d_valid), 32'd0);
      check("s_d_ready", 32'(s_d_ready), 32'd1);
      check("a_quiet_resp", 32'(s_a_valid | m0_a_ready | m1_a_ready), 32'd0);
      exp = exp_q.pop_front();
      check("d_data", m ? m1_d_bits_data : m0_d_bits_data, exp);
      @(negedge clock);
    end
    s_d_valid = 1'b0;
    #1;
    check("state_after", 32'(dbg_state), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    logic [31:0] exp;
    reset = 1'b1;
    set_a(1'b0, 1'b0, 3'd0, 4'd0, 32'h0);
    set_a(1'b1, 1'b0, 3'd0, 4'd0, 32'h0);
    m0_d_ready = 1'b0; m1_d_ready = 1'b0; s_a_ready = 1'b1;
    s_d_valid = 1'b0; s_d_bits_opcode = 3'd1; s_d_bits_param = 2'd0;
    s_d_bits_size = 4'd2; s_d_bits_source = 1'b0; s_d_bits_sink = 1'b0;
    s_d_bits_addr_lo = 2'd0; s_d_bits_data = 32'h0; s_d_bits_error = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_a_valid", 32'(s_a_valid), 32'd0);
    check("rst_s_d_ready", 32'(s_d_ready), 32'd0);

    // Single Get from m0; nothing is accepted during the arbitration cycle.
    @(negedge clock);
    set_a(1'b0, 1'b1, 3'd4, 4'd2, 32'h10000);
    #1;
    check("idle_s_a_valid", 32'(s_a_valid), 32'd0);
    check("idle_a_ready", 32'(m0_a_ready), 32'd0);
    serve(1'b0, 1, 32'h10000, 32'haaaa0000, 1'b0, 1'b0, 1);

    // rr_prio now favours m1, then m0.
    @(negedge clock);
    set_a(1'b0, 1'b1, 3'd4, 4'd2, 32'h11);
    set_a(1'b1, 1'b1, 3'd4, 4'd2, 32'h22);
    serve(1'b1, 1, 32'h22, 32'hb000, 1'b0, 1'b0, 1);
    serve(1'b0, 1, 32'h11, 32'hb100, 1'b0, 1'b0, 1);

    // From reset, both continuously requesting: strict alternation starting at m0.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    set_a(1'b0, 1'b1, 3'd4, 4'd4, 32'h100);
    set_a(1'b1, 1'b1, 3'd4, 4'd4, 32'h200);
    serve(1'b0, 4, 32'h100, 32'h1000, 1'b1, 1'b0, 1);
    serve(1'b1, 4, 32'h200, 32'h2000, 1'b1, 1'b0, 1);
    serve(1'b0, 4, 32'h100, 32'h3000, 1'b0, 1'b0, 1);
    serve(1'b1, 4, 32'h200, 32'h4000, 1'b0, 1'b0, 1);

    // m1 PutFullData; m0 requests mid-response and is served right after.
    @(negedge clock);
    set_a(1'b1, 1'b1, 3'd0, 4'd2, 32'h300);
    serve(1'b1, 1, 32'h300, 32'h5000, 1'b0, 1'b1, 1);
    serve(1'b0, 1, 32'h2000, 32'h6000, 1'b0, 1'b0, 1);

    // Beat counting: clamped size, non-data opcode, Arithmetic, Logical.
    @(negedge clock);
    set_a(1'b0, 1'b1, 3'd4, 4'd8, 32'h400);
    serve(1'b0, 16, 32'h400, 32'h8000, 1'b0, 1'b0, 1);
    @(negedge clock);
    set_a(1'b1, 1'b1, 3'd0, 4'd4, 32'h410);
    serve(1'b1, 1, 32'h410, 32'h8100, 1'b0, 1'b0, 1);
    @(negedge clock);
    set_a(1'b0, 1'b1, 3'd2, 4'd0, 32'h420);
    serve(1'b0, 1, 32'h420, 32'h8200, 1'b0, 1'b0, 1);
    @(negedge clock);
    set_a(1'b1, 1'b1, 3'd3, 4'd3, 32'h430);
    s_d_bits_error = 1'b1;
    serve(1'b1, 2, 32'h430, 32'h8300, 1'b0, 1'b0, 1);
    s_d_bits_error = 1'b0;

    // Unsolicited slave response in IDLE is stalled, not forwarded.
    @(negedge clock);
    s_d_valid = 1'b1;
    s_d_bits_data = 32'hdead;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("unsol_s_d_ready", 32'(s_d_ready), 32'd0);
      check("unsol_d_valid", 32'({m0_d_valid, m1_d_valid}), 32'd0);
      @(negedge clock);
    end
    s_d_valid = 1'b0;

    // Get size 3 with m0_d_ready 1,0,1: two beats, order kept across the stall.
    set_a(1'b0, 1'b1, 3'd4, 4'd3, 32'h500);
    wait_req(k);
    @(negedge clock);
    m0_a_valid = 1'b0;
    s_d_valid = 1'b1; s_d_bits_data = 32'h11; m0_d_ready = 1'b1;
    exp_q.push_back(32'h11);
    #1;
    check("stall_b0_valid", 32'(m0_d_valid), 32'd1);
    exp = exp_q.pop_front();
    check("stall_b0_data", m0_d_bits_data, exp);
    @(negedge clock);
    s_d_bits_data = 32'h22; m0_d_ready = 1'b0;
    exp_q.push_back(32'h22);
    #1;
    check("stall_s_d_ready", 32'(s_d_ready), 32'd0);
    check("stall_b1_valid", 32'(m0_d_valid), 32'd1);
    check("stall_state", 32'(dbg_state), 32'd2);
    @(negedge clock);
    m0_d_ready = 1'b1;
    #1;
    check("stall_b1_ready", 32'(s_d_ready), 32'd1);
    exp = exp_q.pop_front();
    check("stall_b1_data", m0_d_bits_data, exp);
    @(negedge clock);
    s_d_valid = 1'b0;
    #1;
    check("stall_done", 32'(dbg_state), 32'd0);
    check("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // Request withdrawn in REQ before acceptance returns to IDLE.
    @(negedge clock);
    s_a_ready = 1'b0;
    set_a(1'b0, 1'b1, 3'd4, 4'd2, 32'h800);
    wait_req(k);
    m0_a_valid = 1'b0;
    #1;
    check("drop_s_a_valid", 32'(s_a_valid), 32'd0);
    @(negedge clock);
    #1;
    check("drop_state", 32'(dbg_state), 32'd0);
    s_a_ready = 1'b1;

    // Reset in RESP with 2 beats left; outputs clear immediately.
    @(negedge clock);
    set_a(1'b1, 1'b1, 3'd4, 4'd3, 32'h600);
    wait_req(k);
    @(negedge clock);
    m1_a_valid = 1'b0;
    s_d_valid = 1'b1; s_d_bits_data = 32'h66; m1_d_ready = 1'b1;
    #1;
    check("pre_rst_d_valid", 32'(m1_d_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_d_valid", 32'({m0_d_valid, m1_d_valid}), 32'd0);
    check("arst_s_d_ready", 32'(s_d_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    s_d_valid = 1'b0;
    #1;
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_grant", 32'(grant), 32'd0);
    @(negedge clock);
    set_a(1'b1, 1'b1, 3'd4, 4'd2, 32'h700);
    serve(1'b1, 1, 32'h700, 32'h7000, 1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
